// File: rtl/branch_sequencer_pkg.sv
// Shared constants, state type and helpers for the branch sequencer.
package branch_sequencer_pkg;

  localparam int unsigned OPCODE_W    = 7;
  localparam int unsigned FUNCT3_W    = 3;
  localparam int unsigned CNT_W       = 32;
  localparam int unsigned FLUSH_CNT_W = 3;

  localparam logic [OPCODE_W-1:0] BTYPE_OPCODE = 7'b110_0011;
  localparam logic [OPCODE_W-1:0] JAL_OPCODE   = 7'b110_1111;
  localparam logic [OPCODE_W-1:0] JALR_OPCODE  = 7'b110_0111;

  localparam logic [FUNCT3_W-1:0] BREQ_FUNCT3 = 3'b000;
  localparam logic [FUNCT3_W-1:0] BNE_FUNCT3  = 3'b001;
  localparam logic [FUNCT3_W-1:0] BRLT_FUNCT3 = 3'b100;
  localparam logic [FUNCT3_W-1:0] BGE_FUNCT3  = 3'b101;
  localparam logic [FUNCT3_W-1:0] BLTU_FUNCT3 = 3'b110;
  localparam logic [FUNCT3_W-1:0] BGEU_FUNCT3 = 3'b111;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } seq_state_e;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/branch_sequencer_if.sv
// Execute-to-sequencer bus plus the sequencer's fetch/status outputs.
interface branch_sequencer_if
  import branch_sequencer_pkg::*;
#(
  parameter int unsigned AWIDTH = 32
);
  logic                stall_i;
  logic                halt_i;
  logic                ex_valid_i;
  logic [OPCODE_W-1:0] ex_opcode_i;
  logic [FUNCT3_W-1:0] ex_funct3_i;
  logic                breq_i;
  logic                brlt_i;
  logic                brltu_i;
  logic [AWIDTH-1:0]   ex_target_i;
  logic [AWIDTH-1:0]   pc_o;
  logic                fetch_valid_o;
  logic                flush_o;
  logic                taken_o;
  logic                misalign_o;
  logic [CNT_W-1:0]    branch_cnt_o;
  logic [CNT_W-1:0]    taken_cnt_o;

  modport slave (
    input  stall_i, halt_i, ex_valid_i, ex_opcode_i, ex_funct3_i,
           breq_i, brlt_i, brltu_i, ex_target_i,
    output pc_o, fetch_valid_o, flush_o, taken_o, misalign_o,
           branch_cnt_o, taken_cnt_o
  );

  modport master (
    output stall_i, halt_i, ex_valid_i, ex_opcode_i, ex_funct3_i,
           breq_i, brlt_i, brltu_i, ex_target_i,
    input  pc_o, fetch_valid_o, flush_o, taken_o, misalign_o,
           branch_cnt_o, taken_cnt_o
  );

endinterface

// File: rtl/branch_taken_eval.sv
// Combinational taken/not-taken decision from opcode, funct3 and compare flags.
module branch_taken_eval
  import branch_sequencer_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic                breq,
  input  logic                brlt,
  input  logic                brltu,
  output logic                taken_c
);

  always_comb begin
    taken_c = 1'b0;
    case (opcode)
      BTYPE_OPCODE: begin
        case (funct3)
          BREQ_FUNCT3: taken_c = breq;
          BNE_FUNCT3:  taken_c = ~breq;
          BRLT_FUNCT3: taken_c = brlt;
          BGE_FUNCT3:  taken_c = ~brlt;
          BLTU_FUNCT3: taken_c = brltu;
          BGEU_FUNCT3: taken_c = ~brltu;
          default:     taken_c = 1'b0;
        endcase
      end
      JAL_OPCODE, JALR_OPCODE: taken_c = 1'b1;
      default:                 taken_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Program counter owner: redirects fetch on taken branches/jumps, squashes the
// wrong path, keeps branch statistics and halts on misalignment or request.
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int unsigned       AWIDTH       = 32,
  parameter logic [AWIDTH-1:0] BASEADDR     = AWIDTH'(32'h0100_0000),
  parameter int unsigned       FLUSH_CYCLES = 2
) (
  input logic               clk,
  input logic               rst_n,
  branch_sequencer_if.slave bus
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_ONE  = FLUSH_CNT_W'(1);
  localparam logic [AWIDTH-1:0]      PC_STEP    = AWIDTH'(4);

  seq_state_e             state_q, state_d;
  logic [AWIDTH-1:0]      pc_q, pc_d;
  logic [FLUSH_CNT_W-1:0] fcnt_q, fcnt_d;
  logic                   fetch_valid_q, fetch_valid_d;
  logic                   flush_q, flush_d;
  logic                   misalign_q, misalign_d;
  logic [CNT_W-1:0]       branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]       taken_cnt_q, taken_cnt_d;
  logic                   eval_taken_c;
  logic                   taken_c;
  logic                   count_c;

  branch_taken_eval u_eval (
    .opcode  (bus.ex_opcode_i),
    .funct3  (bus.ex_funct3_i),
    .breq    (bus.breq_i),
    .brlt    (bus.brlt_i),
    .brltu   (bus.brltu_i),
    .taken_c (eval_taken_c)
  );

  // Only a live RUN-state instruction may redirect or be counted.
  assign taken_c = (state_q == RUN) && bus.ex_valid_i && !bus.stall_i && eval_taken_c;
  assign count_c = (state_q == RUN) && bus.ex_valid_i && !bus.stall_i &&
                   (bus.ex_opcode_i == BTYPE_OPCODE);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fcnt_d       = fcnt_q;
    misalign_d   = misalign_q;
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;

    if (count_c) begin
      branch_cnt_d = sat_inc(branch_cnt_q);
      if (taken_c) taken_cnt_d = sat_inc(taken_cnt_q);
    end

    case (state_q)
      RUN: begin
        if (!bus.stall_i) begin
          if (bus.halt_i) begin
            state_d = HALT;
          end else if (taken_c && (bus.ex_target_i[1:0] != 2'b00)) begin
            state_d    = HALT;
            misalign_d = 1'b1;
          end else if (taken_c) begin
            pc_d    = bus.ex_target_i;
            fcnt_d  = FLUSH_LOAD;
            state_d = FLUSH;
          end else begin
            pc_d = pc_q + PC_STEP;
          end
        end
      end
      FLUSH: begin
        if (!bus.stall_i) begin
          if (bus.halt_i) begin
            state_d = HALT;
          end else begin
            pc_d   = pc_q + PC_STEP;
            fcnt_d = fcnt_q - FLUSH_ONE;
            if (fcnt_q == FLUSH_ONE) state_d = RUN;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase

    fetch_valid_d = (state_d != HALT);
    flush_d       = (state_d == FLUSH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pc_q          <= BASEADDR;
      fcnt_q        <= '0;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
      branch_cnt_q  <= '0;
      taken_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fcnt_q        <= fcnt_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      misalign_q    <= misalign_d;
      branch_cnt_q  <= branch_cnt_d;
      taken_cnt_q   <= taken_cnt_d;
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.fetch_valid_o = fetch_valid_q;
  assign bus.flush_o       = flush_q;
  assign bus.taken_o       = taken_c;
  assign bus.misalign_o    = misalign_q;
  assign bus.branch_cnt_o  = branch_cnt_q;
  assign bus.taken_cnt_o   = taken_cnt_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: decode table, directed corner sequences and
// randomized traffic against a cycle-level reference model.
module tb_branch_sequencer;
  import branch_sequencer_pkg::*;

  localparam int unsigned AW   = 32;
  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam int          FC   = 2;
  localparam logic [6:0]  OP_ALU = 7'b001_0011;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_sequencer_if #(.AWIDTH(AW)) bus ();

  branch_sequencer #(.AWIDTH(AW), .BASEADDR(BASE), .FLUSH_CYCLES(FC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model state: halted flag, remaining flush cycles, architectural values.
  logic [31:0] m_pc, m_bcnt, m_tcnt;
  bit          m_halted, m_mis, m_fv;
  int          m_fl;

  bit          cur_stall, cur_halt, cur_valid;
  logic [6:0]  cur_op;
  logic [2:0]  cur_f3;
  logic [31:0] cur_rs1, cur_rs2, cur_tgt;

  typedef struct {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       breq;
    logic       brlt;
    logic       brltu;
    logic       exp;
  } vec_t;

  vec_t vecs[18];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Branch semantics stated on the operand values themselves.
  function automatic bit ref_taken(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    sa = a;
    sb = b;
    if (op == JAL_OPCODE || op == JALR_OPCODE) return 1'b1;
    if (op != BTYPE_OPCODE) return 1'b0;
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic drive(input bit stall, input bit halt, input bit valid,
                       input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] tgt);
    cur_stall = stall; cur_halt = halt; cur_valid = valid;
    cur_op = op; cur_f3 = f3; cur_rs1 = rs1; cur_rs2 = rs2; cur_tgt = tgt;
    bus.stall_i     = stall;
    bus.halt_i      = halt;
    bus.ex_valid_i  = valid;
    bus.ex_opcode_i = op;
    bus.ex_funct3_i = f3;
    bus.breq_i      = (rs1 == rs2);
    bus.brlt_i      = ($signed(rs1) < $signed(rs2));
    bus.brltu_i     = (rs1 < rs2);
    bus.ex_target_i = tgt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, OP_ALU, 3'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic check_outputs();
    chk("pc_o", bus.pc_o, m_pc);
    chk("fetch_valid_o", 32'(bus.fetch_valid_o), 32'(m_fv));
    chk("flush_o", 32'(bus.flush_o), 32'(!m_halted && m_fl > 0));
    chk("misalign_o", 32'(bus.misalign_o), 32'(m_mis));
    chk("branch_cnt_o", bus.branch_cnt_o, m_bcnt);
    chk("taken_cnt_o", bus.taken_cnt_o, m_tcnt);
  endtask

  // One clock: check taken_o, take the edge, advance the model, check registers.
  task automatic tick();
    bit tk;
    #1;
    tk = !m_halted && (m_fl == 0) && cur_valid && !cur_stall &&
         ref_taken(cur_op, cur_f3, cur_rs1, cur_rs2);
    chk("taken_o", 32'(bus.taken_o), 32'(tk));
    @(posedge clk);
    if (!m_halted && !cur_stall) begin
      if (m_fl == 0) begin
        if (cur_valid && cur_op == BTYPE_OPCODE) begin
          m_bcnt = sat(m_bcnt);
          if (tk) m_tcnt = sat(m_tcnt);
        end
        if (cur_halt) m_halted = 1'b1;
        else if (tk && cur_tgt[1:0] != 2'b00) begin
          m_halted = 1'b1;
          m_mis    = 1'b1;
        end else if (tk) begin
          m_pc = cur_tgt;
          m_fl = FC;
        end else m_pc = m_pc + 32'd4;
      end else if (cur_halt) begin
        m_halted = 1'b1;
      end else begin
        m_pc = m_pc + 32'd4;
        m_fl--;
      end
    end
    if (m_halted) m_fl = 0;
    m_fv = !m_halted;
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    m_pc = BASE; m_bcnt = '0; m_tcnt = '0;
    m_halted = 1'b0; m_mis = 1'b0; m_fv = 1'b0; m_fl = 0;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{BTYPE_OPCODE, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{BTYPE_OPCODE, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{BTYPE_OPCODE, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{BTYPE_OPCODE, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{BTYPE_OPCODE, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{BTYPE_OPCODE, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{BTYPE_OPCODE, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{BTYPE_OPCODE, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{BTYPE_OPCODE, 3'd6, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{BTYPE_OPCODE, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{BTYPE_OPCODE, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{BTYPE_OPCODE, 3'd7, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{BTYPE_OPCODE, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{BTYPE_OPCODE, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{JAL_OPCODE,   3'd2, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{JALR_OPCODE,  3'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{7'b011_0011,  3'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[17] = '{7'b000_0011,  3'd0, 1'b1, 1'b0, 1'b0, 1'b0};

    idle();
    rst_n = 1'b1;
    #1;

    // Reset and straight-line fetch.
    do_reset();
    chk("reset_pc", bus.pc_o, 32'h0100_0000);
    chk("reset_fetch_valid", 32'(bus.fetch_valid_o), 32'd0);
    idle(); tick(); tick(); tick();
    chk("straight_pc", bus.pc_o, 32'h0100_000C);

    // Taken BEQ: redirect then two flush cycles.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, BTYPE_OPCODE, 3'd0, 32'd7, 32'd7, 32'h0100_0040);
    tick();
    chk("beq_pc", bus.pc_o, 32'h0100_0040);
    chk("beq_flush1", 32'(bus.flush_o), 32'd1);
    idle(); tick();
    chk("beq_flush2", 32'(bus.flush_o), 32'd1);
    tick();
    chk("beq_flush_end", 32'(bus.flush_o), 32'd0);
    chk("beq_bcnt", bus.branch_cnt_o, 32'd1);
    chk("beq_tcnt", bus.taken_cnt_o, 32'd1);

    // Not-taken BGEU.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, BTYPE_OPCODE, 3'd7, 32'd1, 32'd5, 32'h0100_0080);
    tick();
    chk("bgeu_pc", bus.pc_o, 32'h0100_0004);
    chk("bgeu_flush", 32'(bus.flush_o), 32'd0);
    chk("bgeu_tcnt", bus.taken_cnt_o, 32'd0);

    // Stall inside FLUSH stretches the window; wrong-path BNE ignored.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, BTYPE_OPCODE, 3'd0, 32'd3, 32'd3, 32'h0100_0040);
    tick();
    drive(1'b1, 1'b0, 1'b1, BTYPE_OPCODE, 3'd1, 32'd1, 32'd2, 32'h0100_0080);
    tick();
    chk("stall_pc", bus.pc_o, 32'h0100_0040);
    drive(1'b0, 1'b0, 1'b1, BTYPE_OPCODE, 3'd1, 32'd1, 32'd2, 32'h0100_0080);
    tick();
    chk("flush_pc1", bus.pc_o, 32'h0100_0044);
    chk("flush_still_high", 32'(bus.flush_o), 32'd1);
    tick();
    chk("flush_pc2", bus.pc_o, 32'h0100_0048);
    chk("flush_done", 32'(bus.flush_o), 32'd0);
    chk("flush_bcnt", bus.branch_cnt_o, 32'd1);
    // Reset arriving mid-FLUSH.
    drive(1'b0, 1'b0, 1'b1, JAL_OPCODE, 3'd0, 32'd0, 32'd0, 32'h0100_0200);
    tick();
    do_reset();

    // Misaligned JALR halts with PC frozen; reset recovers.
    drive(1'b0, 1'b0, 1'b1, JALR_OPCODE, 3'd0, 32'd0, 32'd0, 32'h0100_0042);
    tick();
    chk("mis_flag", 32'(bus.misalign_o), 32'd1);
    chk("mis_fetch_valid", 32'(bus.fetch_valid_o), 32'd0);
    chk("mis_pc", bus.pc_o, 32'h0100_0000);
    drive(1'b0, 1'b0, 1'b1, JAL_OPCODE, 3'd0, 32'd0, 32'd0, 32'h0100_0100);
    tick(); tick();
    do_reset();

    // Counter saturation and halt beating a same-cycle taken BLT.
    force dut.branch_cnt_q = 32'hFFFF_FFFE;
    force dut.taken_cnt_q  = 32'hFFFF_FFFE;
    #1;
    release dut.branch_cnt_q;
    release dut.taken_cnt_q;
    m_bcnt = 32'hFFFF_FFFE;
    m_tcnt = 32'hFFFF_FFFE;
    drive(1'b0, 1'b0, 1'b1, BTYPE_OPCODE, 3'd1, 32'd9, 32'd9, 32'h0100_0100);
    tick();
    chk("sat_bcnt_top", bus.branch_cnt_o, 32'hFFFF_FFFF);
    drive(1'b0, 1'b1, 1'b1, BTYPE_OPCODE, 3'd4, 32'd1, 32'd2, 32'h0100_0100);
    tick();
    chk("halt_pc", bus.pc_o, 32'h0100_0004);
    chk("halt_misalign", 32'(bus.misalign_o), 32'd0);
    chk("halt_fetch_valid", 32'(bus.fetch_valid_o), 32'd0);
    chk("sat_bcnt_hold", bus.branch_cnt_o, 32'hFFFF_FFFF);
    chk("sat_tcnt_top", bus.taken_cnt_o, 32'hFFFF_FFFF);

    // Decode table: present each vector, sample taken_o, retract before the edge.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      bus.stall_i     = 1'b0;
      bus.halt_i      = 1'b0;
      bus.ex_valid_i  = 1'b1;
      bus.ex_opcode_i = vecs[i].opcode;
      bus.ex_funct3_i = vecs[i].funct3;
      bus.breq_i      = vecs[i].breq;
      bus.brlt_i      = vecs[i].brlt;
      bus.brltu_i     = vecs[i].brltu;
      bus.ex_target_i = 32'h0100_0100;
      #1;
      chk($sformatf("table_taken[%0d]", i), 32'(bus.taken_o), 32'(vecs[i].exp));
      idle();
      tick();
    end

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, b, t;
      logic [6:0]  op;
      int          k;
      if (m_halted && $urandom_range(0, 3) == 0) do_reset();
      a = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
      b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
      t = $urandom;
      t[1:0] = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      k = $urandom_range(0, 9);
      if (k < 5)       op = BTYPE_OPCODE;
      else if (k == 5) op = JAL_OPCODE;
      else if (k == 6) op = JALR_OPCODE;
      else             op = 7'($urandom);
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 99) == 0,
            $urandom_range(0, 9) < 7, op, 3'($urandom), a, b, t);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

- Owns the program counter and sequences control flow for the core.
- Takes branch comparison flags (equal, signed less-than, unsigned less-than) and the computed target from execute, and decides taken/not-taken.
- On a taken branch or jump it redirects fetch and squashes wrong-path instructions for a fixed number of cycles.
- Keeps saturating branch statistics and halts permanently on a misaligned target or an external halt request.

## Interface
Parameters:
- AWIDTH, 32, PC/target width
- BASEADDR, 32'h0100_0000, PC value after reset
- FLUSH_CYCLES, 2, wrong-path cycles squashed after a redirect (legal range 1–7)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- stall_i  in  1  pipeline stall; freezes PC, state and counters
- halt_i  in  1  halt request (e.g. ecall/ebreak retired)
- ex_valid_i  in  1  execute holds a valid instruction
- ex_opcode_i  in  7  execute opcode
- ex_funct3_i  in  3  execute funct3
- breq_i  in  1  rs1 == rs2
- brlt_i  in  1  signed rs1 < rs2
- brltu_i  in  1  unsigned rs1 < rs2
- ex_target_i  in  AWIDTH  branch/jump target computed in execute
- pc_o  out  AWIDTH  current fetch PC
- fetch_valid_o  out  1  fetch may issue at pc_o
- flush_o  out  1  squash the instructions in decode and execute this cycle
- taken_o  out  1  combinational: the execute instruction redirects this cycle
- misalign_o  out  1  sticky: a taken target had target[1:0] != 0
- branch_cnt_o  out  32  B-type instructions resolved
- taken_cnt_o  out  32  B-type instructions taken

## Operation
Taken evaluation (combinational):
- B-type (BTYPE_OPCODE), by funct3:
  - BEQ: breq
  - BNE: !breq
  - BLT: brlt
  - BGE: !brlt
  - BLTU: brltu
  - BGEU: !brltu
  - Any other funct3: not taken.
- JAL/JALR opcodes: always taken.
- All other opcodes: not taken.
- taken_o = state==RUN && ex_valid_i && !stall_i && taken.

States (seq_state_e): RUN, FLUSH, HALT.
- RUN:
  - If stall_i: hold everything.
  - Else if halt_i: go to HALT. halt_i has priority over a same-cycle branch.
  - Else if taken_o and ex_target_i[1:0] != 0: go to HALT and set misalign_o. PC holds.
  - Else if taken_o: pc <= ex_target_i, load flush counter with FLUSH_CYCLES, go to FLUSH.
  - Else: pc <= pc + 4.
- FLUSH:
  - flush_o = 1.
  - ex_valid_i is ignored (wrong path): no redirect and no counting.
  - If not stalled: pc <= pc + 4 and the counter decrements. Go to RUN when it reaches 1→0.
  - halt_i while not stalled: go to HALT.
- HALT:
  - fetch_valid_o = 0, flush_o = 0, pc frozen.
  - Exit only through rst_n.

Counters:
- Counted in RUN, not stalled, ex_valid_i, opcode == BTYPE_OPCODE.
- branch_cnt_o increments on every such instruction. taken_cnt_o increments when that instruction is also taken.
- Jumps are not counted.
- Both counters saturate at 32'hFFFF_FFFF.
- A misaligned taken branch still counts.

Arithmetic:
- pc + 4 wraps modulo 2^AWIDTH with no flag.

## Timing
Reset values (asynchronous on rst_n low):
- pc_o = BASEADDR
- state = RUN
- fetch_valid_o = 0; it becomes 1 on the first rising edge after rst_n deasserts.
- flush_o = 0, misalign_o = 0, counters = 0.
- Reset asserted mid-FLUSH or in HALT aborts immediately to these values.

Latency and flush timing:
- Redirect latency is 1 cycle: pc_o shows the target on the edge after taken_o.
- flush_o is registered. It is high for exactly FLUSH_CYCLES unstalled cycles, starting the cycle after taken_o. Stall cycles extend the window; flush_o stays high during them.
- A redirect on the last FLUSH cycle is impossible, because ex_valid_i is ignored in FLUSH. The first RUN cycle after FLUSH may redirect again.
- taken_o is combinational from the ex_* inputs and has no state dependence beyond state==RUN.

## Structure
Add to the shared constants package:
- BNE/BGE/BLTU/BGEU funct3 values (BTYPE_OPCODE, BREQ_FUNCT3 and BRLT_FUNCT3 already exist).
- JAL_OPCODE and JALR_OPCODE.
- seq_state_e typedef.

Sub-module:
- branch_taken_eval: purely combinational taken decision from opcode, funct3 and the three flags.
- branch_sequencer holds the PC, FSM, flush counter and statistics.

## Test plan
- Reset and straight-line fetch: rst_n low → pc_o = 32'h0100_0000, fetch_valid_o = 0. After release, 3 unstalled cycles → pc_o = 0x0100_000C.
- Taken BEQ: breq_i = 1, funct3 = 000, target 0x0100_0040 → taken_o = 1. Next cycle pc_o = 0x0100_0040, flush_o high 2 cycles, branch_cnt_o = taken_cnt_o = 1.
- Not-taken BGEU: brltu_i = 1 → pc_o advances by 4, flush_o = 0, branch_cnt_o = 1, taken_cnt_o = 0.
- Stall during FLUSH: stall_i high in the first flush cycle → pc_o holds, flush_o remains high for 3 total cycles. A valid taken BNE presented during FLUSH is ignored.
- Misaligned JALR: target 0x0100_0042 → state HALT, misalign_o = 1, fetch_valid_o = 0, pc_o unchanged. rst_n low restores all reset values.
- Same-cycle halt_i and taken BLT → HALT wins, pc_o unchanged, misalign_o = 0. Also preload the counter to 32'hFFFF_FFFF and check it saturates.
